// File: rtl/hack_pkg.sv
// ============================================================================
// Module      : hack_pkg
// Description : Shared types and instruction field positions for the Hack
//               CPU control block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MREAD  = 3'd3,
    S_EXEC   = 3'd4,
    S_MWRITE = 3'd5
  } state_t;

  localparam int c_TYPE_BIT = 15;
  localparam int c_ABIT     = 12;
  localparam int c_CMP_HI   = 11;
  localparam int c_CMP_LO   = 6;
  localparam int c_DST_HI   = 5;
  localparam int c_DST_LO   = 3;
  localparam int c_JMP_HI   = 2;
  localparam int c_JMP_LO   = 0;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic alu_ctrl_t decode_cmp(input logic [15:0] instr);
    return alu_ctrl_t'(instr[c_CMP_HI:c_CMP_LO]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hack_jump_cond.sv
// ============================================================================
// Module      : hack_jump_cond
// Description : Evaluates the Hack jump field against the ALU flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_jump_cond (
  input  logic [2:0] jmp,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  // jmp[2]=lt, jmp[1]=eq, jmp[0]=gt
  assign taken = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);

endmodule

`default_nettype wire

// File: rtl/hack_cpu_ctrl.sv
// ============================================================================
// Module      : hack_cpu_ctrl
// Description : Multi-cycle Hack CPU control/datapath feeding an external ALU,
//               with req/ack instruction and data memory sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [14:0] dmem_addr,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic        instr_done
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_ir;
  logic [15:0] r_mdr;
  logic [15:0] r_wdata;
  logic [14:0] r_pc;
  logic [14:0] r_waddr;

  logic        w_is_c;
  logic        w_abit;
  logic [2:0]  w_dst;
  logic [2:0]  w_jmp;
  logic        w_taken;
  alu_ctrl_t   w_alu_ctrl;

  assign w_is_c     = r_ir[c_TYPE_BIT];
  assign w_abit     = r_ir[c_ABIT];
  assign w_dst      = r_ir[c_DST_HI:c_DST_LO];
  assign w_jmp      = r_ir[c_JMP_HI:c_JMP_LO];
  assign w_alu_ctrl = decode_cmp(r_ir);

  hack_jump_cond u_jump_cond (
    .jmp   (w_jmp),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (w_taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_done  = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!w_is_c) begin
          instr_done  = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_abit) begin
          w_state_nxt = S_MREAD;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_MREAD: begin
        if (dmem_ack) begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_dst[0]) begin
          w_state_nxt = S_MWRITE;
        end else begin
          instr_done  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_MWRITE: begin
        if (dmem_ack) begin
          instr_done  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // The jump target and write address use A before this cycle's d1 update,
  // which non-blocking assignment gives us for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= 16'h0000;
      r_d     <= 16'h0000;
      r_ir    <= 16'h0000;
      r_mdr   <= 16'h0000;
      r_wdata <= 16'h0000;
      r_pc    <= 15'h0000;
      r_waddr <= 15'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_data;
          end
        end
        S_DECODE: begin
          if (!w_is_c) begin
            r_a  <= {1'b0, r_ir[14:0]};
            r_pc <= r_pc + 15'd1;
          end
        end
        S_MREAD: begin
          if (dmem_ack) begin
            r_mdr <= dmem_rdata;
          end
        end
        S_EXEC: begin
          if (w_dst[2]) begin
            r_a <= alu_out;
          end
          if (w_dst[1]) begin
            r_d <= alu_out;
          end
          if (w_dst[0]) begin
            r_waddr <= r_a[14:0];
            r_wdata <= alu_out;
          end
          r_pc <= w_taken ? r_a[14:0] : (r_pc + 15'd1);
        end
        default: begin
        end
      endcase
    end
  end

  // All memory-side outputs decode from registered state only.
  assign imem_addr  = r_pc;
  assign imem_req   = (r_state == S_FETCH);
  assign dmem_rd    = (r_state == S_MREAD);
  assign dmem_wr    = (r_state == S_MWRITE);
  assign dmem_addr  = dmem_rd ? r_a[14:0] : (dmem_wr ? r_waddr : 15'h0000);
  assign dmem_wdata = dmem_wr ? r_wdata : 16'h0000;

  assign alu_x  = r_d;
  assign alu_y  = w_abit ? r_mdr : r_a;
  assign alu_zx = w_alu_ctrl.zx;
  assign alu_nx = w_alu_ctrl.nx;
  assign alu_zy = w_alu_ctrl.zy;
  assign alu_ny = w_alu_ctrl.ny;
  assign alu_f  = w_alu_ctrl.f;
  assign alu_no = w_alu_ctrl.no;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu_ctrl.sv
// ============================================================================
// Module      : tb_hack_cpu_ctrl
// Description : Directed self-checking bench for hack_cpu_ctrl with memory
//               responders and a behavioural Hack ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hack_cpu_ctrl;

  logic        clk;
  logic        reset;
  logic [14:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [14:0] dmem_addr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic [15:0] dmem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic        instr_done;

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  int          iw_cfg, dw_cfg, iw_cnt, dw_cnt;
  logic        stray_dack;
  int          wr_cnt;
  logic [14:0] last_waddr;
  logic [15:0] last_wdata;
  logic [15:0] m_x, m_y, m_o;

  int n_cmp, n_err;

  hack_cpu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_rd    (dmem_rd),
    .dmem_wr    (dmem_wr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_zx     (alu_zx),
    .alu_nx     (alu_nx),
    .alu_zy     (alu_zy),
    .alu_ny     (alu_ny),
    .alu_f      (alu_f),
    .alu_no     (alu_no),
    .alu_out    (alu_out),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hack ALU reference
  always_comb begin
    m_x = alu_x;
    if (alu_zx) m_x = 16'h0000;
    if (alu_nx) m_x = ~m_x;
    m_y = alu_y;
    if (alu_zy) m_y = 16'h0000;
    if (alu_ny) m_y = ~m_y;
    m_o = alu_f ? (m_x + m_y) : (m_x & m_y);
    if (alu_no) m_o = ~m_o;
  end
  assign alu_out = m_o;
  assign alu_zr  = (m_o == 16'h0000);
  assign alu_ng  = m_o[15];

  // Memory responders with programmable wait cycles
  assign imem_ack   = imem_req && (iw_cnt >= iw_cfg);
  assign imem_data  = imem[imem_addr];
  assign dmem_ack   = ((dmem_rd || dmem_wr) && (dw_cnt >= dw_cfg)) || stray_dack;
  assign dmem_rdata = dmem[dmem_addr];

  initial begin
    wr_cnt     = 0;
    last_waddr = '0;
    last_wdata = '0;
  end

  always @(posedge clk) begin
    iw_cnt <= (imem_req && !imem_ack) ? iw_cnt + 1 : 0;
    dw_cnt <= ((dmem_rd || dmem_wr) && !dmem_ack) ? dw_cnt + 1 : 0;
    if (dmem_wr && dmem_ack) begin
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= dmem_addr;
      last_wdata <= dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance to the first cycle of the next fetch request.
  task automatic run_to_fetch(input string tag, input logic [14:0] exp_addr);
    logic was;
    logic found;
    was   = imem_req;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_req && !was) found = 1'b1;
      was = imem_req;
    end
    chk({tag, "_seen"}, {15'h0, found}, 16'h0001);
    chk({tag, "_addr"}, {1'b0, imem_addr}, {1'b0, exp_addr});
  endtask

  logic [9:0] done_mask;
  int         wr_before;

  initial begin
    reset      = 1'b1;
    iw_cfg     = 0;
    dw_cfg     = 0;
    iw_cnt     = 0;
    dw_cnt     = 0;
    stray_dack = 1'b0;
    n_cmp      = 0;
    n_err      = 0;

    // ---- A/C sequence, zero wait, stray dmem_ack present ----
    clear_mem();
    imem[0] = 16'h0005;
    imem[1] = 16'hEC10;
    imem[2] = 16'h0007;
    imem[3] = 16'hE090;
    imem[4] = 16'h0004;
    imem[5] = 16'hEA87;
    do_reset();
    chk("boot_imem_req", {15'h0, imem_req}, 16'h0000);
    chk("boot_dmem_rd_wr", {14'h0, dmem_rd, dmem_wr}, 16'h0000);
    chk("boot_done", {15'h0, instr_done}, 16'h0000);
    chk("boot_alu_x", alu_x, 16'h0000);
    chk("boot_alu_ctrl", {10'h0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0000);
    stray_dack = 1'b1;
    done_mask  = '0;
    for (int c = 1; c <= 10; c++) begin
      step();
      done_mask[c-1] = instr_done;
      if (c == 1) chk("seq_fetch0", {imem_req, imem_addr}, 16'h8000);
      if (c == 5) begin
        chk("seq_ctrl_d_eq_a", {10'h0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, 16'h0030);
        chk("seq_alu_y_a", alu_y, 16'h0005);
      end
      if (c == 8) chk("seq_fetch3", {imem_req, imem_addr}, 16'h8003);
    end
    chk("seq_done_mask", {6'h0, done_mask}, 16'h0252);
    step();
    chk("seq_final_d", alu_x, 16'h000C);
    chk("seq_no_dmem", {14'h0, dmem_rd, dmem_wr}, 16'h0000);
    stray_dack = 1'b0;

    // ---- memory read-modify-write ----
    clear_mem();
    dmem[3] = 16'h0010;
    imem[0] = 16'h0003;
    imem[1] = 16'hFDC8;
    imem[2] = 16'h0002;
    imem[3] = 16'hEA87;
    do_reset();
    wr_before = wr_cnt;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 5) chk("mrd_rd_addr", {dmem_rd, dmem_addr}, 16'h8003);
      if (c == 6) chk("mrd_alu_y_mdr", alu_y, 16'h0010);
      if (c == 7) begin
        chk("mwr_wr_addr", {dmem_wr, dmem_addr}, 16'h8003);
        chk("mwr_wdata", dmem_wdata, 16'h0011);
        chk("mwr_done", {15'h0, instr_done}, 16'h0001);
      end
    end
    step();
    chk("mwr_commit_cnt", 16'(wr_cnt - wr_before), 16'h0001);
    chk("mwr_commit", {1'b0, last_waddr}, 16'h0003);

    // ---- jumps with A=0x20 ----
    clear_mem();
    imem[0]     = 16'hEE90;
    imem[1]     = 16'h0020;
    imem[2]     = 16'hE304;
    imem[16'h20] = 16'hEA90;
    imem[16'h21] = 16'h0020;
    imem[16'h22] = 16'hE301;
    imem[16'h23] = 16'hEA87;
    do_reset();
    run_to_fetch("jmp_f0", 15'h0000);
    run_to_fetch("jmp_f1", 15'h0001);
    chk("jmp_d_minus1", alu_x, 16'hFFFF);
    run_to_fetch("jmp_f2", 15'h0002);
    run_to_fetch("jmp_jlt_taken", 15'h0020);
    run_to_fetch("jmp_f21", 15'h0021);
    chk("jmp_d_zero", alu_x, 16'h0000);
    run_to_fetch("jmp_f22", 15'h0022);
    run_to_fetch("jmp_jgt_not_taken", 15'h0023);
    run_to_fetch("jmp_always", 15'h0020);

    // ---- AM=A+1 with A=4, two write wait cycles ----
    clear_mem();
    imem[0] = 16'h0004;
    imem[1] = 16'hEDE8;
    imem[2] = 16'hEC10;
    imem[3] = 16'h0003;
    imem[4] = 16'hEA87;
    dw_cfg  = 2;
    do_reset();
    wr_before = wr_cnt;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c >= 6) begin
        chk("am_wr_held", {dmem_wr, dmem_addr}, 16'h8004);
        chk("am_wdata", dmem_wdata, 16'h0005);
      end
      if (c == 6) chk("am_done_early", {15'h0, instr_done}, 16'h0000);
      if (c == 8) chk("am_done", {15'h0, instr_done}, 16'h0001);
    end
    run_to_fetch("am_f2", 15'h0002);
    chk("am_commit", {last_wdata[7:0], 1'b0, last_waddr[6:0]}, 16'h0504);
    chk("am_commit_cnt", 16'(wr_cnt - wr_before), 16'h0001);
    run_to_fetch("am_f3", 15'h0003);
    chk("am_a_after", alu_x, 16'h0005);

    // ---- reset during MWRITE ----
    dw_cfg = 5;
    do_reset();
    wr_before = wr_cnt;
    for (int c = 1; c <= 6; c++) step();
    chk("rst_pre_wr", {15'h0, dmem_wr}, 16'h0001);
    #1 reset = 1'b1;
    #1 chk("rst_wr_drop", {15'h0, dmem_wr}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_no_partial_wr", 16'(wr_cnt - wr_before), 16'h0000);
    chk("rst_boot_req", {imem_req, imem_addr}, 16'h0000);
    chk("rst_boot_a", alu_y, 16'h0000);
    chk("rst_boot_d", alu_x, 16'h0000);
    step();
    chk("rst_fetch0", {imem_req, imem_addr}, 16'h8000);
    dw_cfg = 0;

    // ---- fetch wait states and PC wrap ----
    clear_mem();
    imem[0]     = 16'h7FFF;
    imem[1]     = 16'hEA87;
    imem[32767] = 16'h0000;
    iw_cfg      = 3;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("wait_req_held", {imem_req, imem_addr}, 16'h8000);
      chk("wait_no_done", {15'h0, instr_done}, 16'h0000);
    end
    step();
    chk("wait_decode", {15'h0, imem_req}, 16'h0000);
    run_to_fetch("wrap_f1", 15'h0001);
    run_to_fetch("wrap_f7fff", 15'h7FFF);
    chk("wrap_a", alu_y, 16'h7FFF);
    run_to_fetch("wrap_f0", 15'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle Hack CPU control and datapath that sits directly upstream of the Hack ALU. It fetches 16-bit Hack instructions, holds the A, D and PC registers, and drives the ALU operands and the six control bits. It consumes the ALU result and flags for writeback and jumps, and sequences data-memory reads and writes over a req/ack handshake.

## Interface
- No parameters; widths are fixed by the Hack ISA (16-bit data, 15-bit addresses).
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_addr  out  15  instruction address; equals PC.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; imem_data is valid in the same cycle.
- imem_data  in  16  instruction word.
- dmem_addr  out  15  data address.
- dmem_rd  out  1  data read request.
- dmem_wr  out  1  data write request.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data; valid when dmem_ack is high.
- dmem_ack  in  1  data access complete.
- alu_x  out  16  always the D register.
- alu_y  out  16  the MDR if IR[12]=1, otherwise the A register.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  driven from IR[11:6], in that order.
- alu_out  in  16  ALU result (combinational).
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- instr_done  out  1  one-cycle pulse per retired instruction.

## Operation
- FSM states: BOOT, FETCH, DECODE, MREAD, EXEC, MWRITE.
- **BOOT:** entered on reset; moves to FETCH on the next clock.
- **FETCH:** imem_req=1. When imem_ack=1, IR<=imem_data and the FSM moves to DECODE. Otherwise it stays in FETCH.
- **DECODE, A-instruction (IR[15]=0):**
  - A<=IR[14:0] zero-extended to 16 bits.
  - PC<=PC+1.
  - instr_done=1; next state FETCH.
- **DECODE, C-instruction:** goes to MREAD if IR[12]=1, otherwise to EXEC.
- **MREAD:**
  - dmem_rd=1 and dmem_addr=A[14:0].
  - On dmem_ack, MDR<=dmem_rdata and the FSM moves to EXEC.
- **EXEC:** the ALU is combinational, so alu_out is valid in this cycle. Let d1=IR[5], d2=IR[4], d3=IR[3].
  - If d1=1, A<=alu_out. If d2=1, D<=alu_out.
  - If d3=1, WADDR<=old A[14:0] and WDATA<=alu_out; next state MWRITE.
  - If d3=0, instr_done=1; next state FETCH.
- **Jump (decided in EXEC):** let j1=IR[2], j2=IR[1], j3=IR[0].
  - Taken when (j1&alu_ng) | (j2&alu_zr) | (j3&~alu_ng&~alu_zr).
  - If taken, PC<=old A[14:0]; otherwise PC<=PC+1.
  - "Old A" is the value before any same-instruction d1 write.
- **MWRITE:**
  - dmem_wr=1, dmem_addr=WADDR, dmem_wdata=WDATA.
  - On dmem_ack, instr_done=1 and the FSM moves to FETCH.
- C-instructions ignore IR[14:13].
- PC is 15 bits and wraps: 0x7FFF+1 = 0x0000.
- A jump to PC's own address is legal; this is the Hack halt idiom.

## Timing
- **Reset values:**
  - A, D, PC, IR, MDR, WADDR and WDATA are all 0; state is BOOT.
  - All outputs are 0, including the requests and instr_done.
- **Output style:** outputs are decoded from registered state only (Moore). There is no combinational path from any ack input to any request output.
- **Handshake:**
  - A request is held high until ack is sampled high.
  - Ack is accepted in the first cycle of the request, so the minimum access time is 1 cycle.
  - An ack arriving outside its matching request is ignored.
  - The address and write data are stable for the whole request.
- **Minimum cycles per instruction (zero-wait memory):**
  - A-instruction: 2 (FETCH, DECODE).
  - C-instruction without memory: 3.
  - C-instruction with M read: 4.
  - C-instruction with M write: 4.
  - C-instruction with both M read and M write: 5.
  - Each wait cycle adds one cycle.
- **Register update timing:**
  - Register updates occur at the edge that leaves the state.
  - instr_done is high during the final cycle of the instruction.
- **Reset mid-operation:** all requests drop immediately, because reset is asynchronous. No partial write is retried, and the next fetch is from PC=0.

## Structure
- Shared package hack_pkg holds:
  - the state enum;
  - instruction field positions (TYPE=15, ABIT=12, CMP=11:6, DST=5:3, JMP=2:0);
  - the ALU control struct {zx,nx,zy,ny,f,no}.
- The ALU is external. This block drives it over the alu_* ports and does not instantiate it.
- One combinational sub-module, hack_jump_cond, takes (jmp[2:0], zr, ng) and produces taken.

## Test plan
- **Reset and boot:** assert reset mid-MWRITE.
  - dmem_wr falls in the same cycle.
  - After release: BOOT, then FETCH with imem_addr=0.
  - A, D and PC are all 0.
- **A/C sequence, zero-wait memory:** run @5, D=A (0xEC10), @7, D=D+A (0xE090).
  - Final D=0x000C.
  - instr_done pulses at cycles 2, 5, 7 and 10.
- **Memory read/write:** M[3]=0x0010; run @3, M=M+1 (0xFDC8).
  - dmem_rd to address 3, then dmem_wr to address 3 with data 0x0011.
- **Jumps, with A=0x0020:**
  - D=-1 with JLT (0xE304 after D set): PC becomes 0x20.
  - D=0 with JGT: PC becomes PC+1.
  - 0;JMP (0xEA87): always taken.
- **Same-instruction A write and M write:** AM=A+1 with A=4.
  - The write goes to address 4 with data 5.
  - After the instruction, A=5.
- **Wait states and wrap-around:**
  - imem_ack delayed 3 cycles: imem_req is held and imem_addr is stable throughout.
  - A-instruction executed at PC=0x7FFF: the next fetch address is 0x0000.
